// File: rtl/victim_wb_pkg.sv
// victim_wb_pkg: drain-FSM state encoding and AXI4 burst/size/response constants.
package victim_wb_pkg;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} wb_state_e;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    function automatic logic [2:0] axi_size(input int bytes);
        return 3'($clog2(bytes));
    endfunction
endpackage

// File: rtl/victim_writeback.sv
// victim_writeback: pops one dirty line from the victim FIFO and writes it out as one AXI4 INCR burst.
// Optional VICTIM_WB_QUERY_EN exposes the in-flight line to same-cycle cache lookups.
module victim_writeback
    import victim_wb_pkg::*;
#(
    parameter int         LINE_WIDTH  = 256,
    parameter int         DATA_WIDTH  = 32,
    parameter logic [3:0] AXI_ID      = 4'd0,
    localparam int        BEATS       = LINE_WIDTH / DATA_WIDTH,
    localparam int        BW          = $clog2(BEATS),
    localparam int        LABEL_WIDTH = 32 - $clog2(LINE_WIDTH / 8)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [LABEL_WIDTH+LINE_WIDTH-1:0] fifo_line,
    input  logic                              fifo_empty,
    output logic                              fifo_pop,
    output logic [31:0]                       awaddr,
    output logic [7:0]                        awlen,
    output logic [2:0]                        awsize,
    output logic [1:0]                        awburst,
    output logic [3:0]                        awid,
    output logic                              awvalid,
    input  logic                              awready,
    output logic [DATA_WIDTH-1:0]             wdata,
    output logic [DATA_WIDTH/8-1:0]           wstrb,
    output logic                              wlast,
    output logic                              wvalid,
    input  logic                              wready,
    input  logic                              bvalid,
    output logic                              bready,
    input  logic [1:0]                        bresp,
    input  logic [LABEL_WIDTH-1:0]            q_label,
    output logic                              q_found,
    output logic [LINE_WIDTH-1:0]             q_rdata,
    output logic                              idle,
    output logic                              bus_err
);
    wb_state_e              state, state_nx;
    logic [BW-1:0]          beat;
    logic [LABEL_WIDTH-1:0] buf_label;
    logic [LINE_WIDTH-1:0]  buf_data;
    logic                   buf_v;

    assign awaddr  = {buf_label, {(32-LABEL_WIDTH){1'b0}}};
    assign awlen   = 8'(BEATS - 1);
    assign awsize  = axi_size(DATA_WIDTH / 8);
    assign awburst = AXI_BURST_INCR;
    assign awid    = AXI_ID;
    assign wstrb   = '1;
    assign wdata   = buf_data[32'(beat) * DATA_WIDTH +: DATA_WIDTH];
    assign wlast   = wvalid && (beat == BW'(BEATS - 1));
    assign idle    = (state == IDLE);

    always_comb begin
        state_nx = state;
        fifo_pop = 1'b0;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        case (state)
            IDLE: begin
                fifo_pop = ~fifo_empty;
                state_nx = fifo_empty ? IDLE : ADDR;
            end
            ADDR: begin
                awvalid  = 1'b1;
                state_nx = awready ? DATA : ADDR;
            end
            DATA: begin
                wvalid   = 1'b1;
                state_nx = (wready && wlast) ? RESP : DATA;
            end
            RESP: begin
                bready   = 1'b1;
                state_nx = bvalid ? IDLE : RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    // beat wraps to 0 on the last accepted beat, so every burst starts at beat 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            buf_label <= '0;
            buf_data  <= '0;
            buf_v     <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (fifo_pop) begin
                {buf_label, buf_data} <= fifo_line;
                buf_v                 <= 1'b1;
            end
            if (wvalid && wready) beat <= beat + 1'b1;
            if (bready && bvalid) begin
                buf_v   <= 1'b0;
                bus_err <= bus_err | (bresp != AXI_RESP_OKAY);
            end
        end
    end

`ifdef VICTIM_WB_QUERY_EN
    assign q_found = buf_v && (buf_label == q_label);
    assign q_rdata = buf_data;
`else
    logic unused_query;
    assign unused_query = ^{q_label, buf_v};
    assign q_found      = 1'b0;
    assign q_rdata      = '0;
`endif
endmodule

// File: tb/tb_victim_writeback.sv
// tb_victim_writeback: scoreboard bench for victim_writeback with a FIFO model and a zero-latency AXI slave.
module tb_victim_writeback;
    localparam int LW = 256, DW = 32, BEATS = 8, LBW = 27;
    typedef struct packed {logic [DW-1:0] data; logic last;} wexp_t;

    logic              clk = 0, rst_n = 1;
    logic [LBW+LW-1:0] fifo_line = '0;
    logic              fifo_empty = 1, fifo_pop;
    logic [31:0]       awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst, bresp;
    logic [3:0]        awid;
    logic              awvalid, awready = 1;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wlast, wvalid, wready = 1, bvalid, bready;
    logic [LBW-1:0]    q_label = '0;
    logic              q_found, idle, bus_err;
    logic [LW-1:0]     q_rdata;

    victim_writeback dut (
        .clk(clk), .rst_n(rst_n), .fifo_line(fifo_line), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .q_label(q_label), .q_found(q_found), .q_rdata(q_rdata), .idle(idle), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [LBW+LW-1:0] fifo_q[$];
    logic [31:0]       aw_q[$];
    wexp_t             w_q[$];
    int                gap_q[$];
    int total = 0, bad = 0;
    int pops = 0, w_hs = 0, b_cnt = 0, err_at = -1, cyc = 0, last_aw_cyc = 0;
    bit pop_now = 0, b_now = 0, toggle_w = 0, stall = 0;
    logic [DW:0]  held = '0;
    logic [31:0]  last_awaddr = '0;

    assign bvalid = bready;
    assign bresp  = (b_cnt == err_at) ? 2'b10 : 2'b00;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk_data(input logic [31:0] base);
        logic [LW-1:0] d;
        for (int k = 0; k < BEATS; k++) d[k*DW +: DW] = base + 32'(k);
        return d;
    endfunction

    // call only at posedge+2 so the monitor sees the resulting pop at the next negedge
    task automatic push(input logic [LBW-1:0] lab, input logic [31:0] base);
        for (int k = 0; k < BEATS; k++) w_q.push_back({base + 32'(k), k == BEATS - 1});
        fifo_q.push_back({lab, mk_data(base)});
        aw_q.push_back({lab, 5'b0});
        fifo_empty = 0;
        fifo_line  = fifo_q[0];
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(idle && fifo_empty && w_q.size() == 0 && aw_q.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 256'(n < 300), 256'(1));
    endtask

    always @(negedge clk) begin
        wexp_t e;
        cyc++;
        if (rst_n) begin
            check("aw_w_excl", 256'(awvalid & wvalid), 256'(0));
            if (stall) check("w_hold", {wvalid, wdata, wlast}, {1'b1, held});
            stall = wvalid && !wready;
            held  = {wdata, wlast};
            if (awvalid && awready) begin
                if (aw_q.size() == 0) check("aw_unexp", 256'(aw_q.size()), 256'(1));
                else begin
                    check("awaddr", 256'(awaddr), 256'(aw_q.pop_front()));
                    check("awlen", 256'(awlen), 256'(7));
                    check("awsize", 256'(awsize), 256'(2));
                    check("awburst", 256'(awburst), 256'(1));
                    check("awid", 256'(awid), 256'(0));
                end
                gap_q.push_back(cyc - last_aw_cyc);
                last_aw_cyc = cyc;
                last_awaddr = awaddr;
            end
            if (wvalid && wready) begin
                if (w_q.size() == 0) check("w_unexp", 256'(w_q.size()), 256'(1));
                else begin
                    e = w_q.pop_front();
                    check("wbeat", 256'({wdata, wlast}), 256'({e.data, e.last}));
                    check("wstrb", 256'(wstrb), 256'(4'hf));
                end
                w_hs++;
            end
            pop_now = fifo_pop;
            b_now   = bvalid && bready;
        end else begin
            stall   = 0;
            pop_now = 0;
            b_now   = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pop_now && rst_n && fifo_q.size() != 0) begin
            pops++;
            void'(fifo_q.pop_front());
        end
        pop_now = 0;
        if (b_now) b_cnt++;
        b_now = 0;
        if (toggle_w) wready = ~wready;
        fifo_empty = (fifo_q.size() == 0);
        fifo_line  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    initial begin
        int n, base, p0;
        #2 rst_n = 0;
        #1;
        check("rst_idle", 256'(idle), 256'(1));
        check("rst_outs", 256'({awvalid, wvalid, bready, fifo_pop, bus_err, q_found}), 256'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1;

        // 1: single line, zero-wait slave
        @(posedge clk); #2;
        push(27'h0123456, 32'd0);
        drain("t1");
        check("t1_awaddr", 256'(last_awaddr), 256'(32'h02468AC0));
        check("t1_beats", 256'(w_hs), 256'(8));
        check("t1_pops", 256'(pops), 256'(1));

        // 2: W backpressure, wready toggling
        toggle_w = 1;
        @(posedge clk); #2;
        push(27'h1ABCDE, 32'h100);
        drain("t2");
        toggle_w = 0;
        wready   = 1;
        check("t2_beats", 256'(w_hs), 256'(16));

        // 3: three lines back-to-back, one IDLE bubble each
        @(posedge clk); #2;
        p0 = pops;
        gap_q.delete();
        push(27'h0000A0A, 32'h200);
        push(27'h0000B0B, 32'h300);
        push(27'h0000C0C, 32'h400);
        drain("t3");
        check("t3_pops", 256'(pops - p0), 256'(3));
        check("t3_aws", 256'(gap_q.size()), 256'(3));
        if (gap_q.size() == 3) begin
            check("t3_gap1", 256'(gap_q[1]), 256'(11));
            check("t3_gap2", 256'(gap_q[2]), 256'(11));
        end
        check("t3_no_err", 256'(bus_err), 256'(0));

        // 4: SLVERR on the second of three lines
        @(posedge clk); #2;
        base   = w_hs;
        err_at = b_cnt + 1;
        push(27'h0001111, 32'h10);
        push(27'h0002222, 32'h20);
        push(27'h0003333, 32'h30);
        drain("t4");
        check("t4_err", 256'(bus_err), 256'(1));
        check("t4_beats", 256'(w_hs - base), 256'(24));
        repeat (3) @(negedge clk);
        check("t4_sticky", 256'(bus_err), 256'(1));

        // 5: query the in-flight line mid-DATA
        @(posedge clk); #2;
        push(27'h5A5A5A5, 32'h500);
        n = 0;
        while (!wvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_in_data", 256'(wvalid), 256'(1));
        q_label = 27'h5A5A5A5;
        #1;
`ifdef VICTIM_WB_QUERY_EN
        check("q_hit", 256'(q_found), 256'(1));
        check("q_rdata", q_rdata, mk_data(32'h500));
        q_label = 27'h5A5A5A4;
        #1;
        check("q_miss", 256'(q_found), 256'(0));
        drain("t5");
        q_label = 27'h5A5A5A5;
        #1;
        check("q_after", 256'(q_found), 256'(0));
`else
        check("q_off_found", 256'(q_found), 256'(0));
        check("q_off_rdata", q_rdata, '0);
        drain("t5");
`endif

        // 6: async reset at DATA beat 3, then a fresh burst
        @(posedge clk); #2;
        base = w_hs;
        push(27'h0777777, 32'h600);
        n = 0;
        while (w_hs < base + 3 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("t6_beat3", 256'(wdata), 256'(32'h603));
        rst_n = 0;
        #1;
        check("t6_rst_idle", 256'(idle), 256'(1));
        check("t6_rst_outs", 256'({awvalid, wvalid, wlast, bready, fifo_pop, bus_err}), 256'(0));
        w_q.delete();
        aw_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #2;
        push(27'h0111111, 32'h700);
        drain("t6");
        check("t6_beats", 256'(w_hs - base), 256'(11));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
